// File: rtl/ica_dca_mem_responder_if.sv
// Bus bundle between the display-control initiator, the burst responder and
// the 64-bit memory port.
interface ica_dca_mem_responder_if;
    logic [21:0] address;
    logic        as;
    logic [15:0] dout;
    logic        burstdata_valid;
    logic        bus_ack;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_valid;
    logic [63:0] mem_rdata;

    modport slave (
        input  address, as, mem_valid, mem_rdata,
        output dout, burstdata_valid, bus_ack, mem_req, mem_addr
    );

    modport master (
        output address, as, mem_valid, mem_rdata,
        input  dout, burstdata_valid, bus_ack, mem_req, mem_addr
    );
endinterface

// File: rtl/ica_dca_mem_responder.sv
// Fetches one 64-bit line per address strobe and replays it to the initiator
// as a 4-word critical-word-first burst with a configurable inter-word gap.
module ica_dca_mem_responder #(
    parameter int GAP = 0
) (
    input logic                     clk,
    input logic                     reset,
    ica_dca_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DRAIN} state_t;

    localparam logic [2:0] GAP_LOAD = 3'(GAP);

    state_t      r_state, w_nextState;
    logic        r_memReq, w_memReq;
    logic [18:0] r_memAddr, w_memAddr;
    logic [1:0]  r_startIdx, w_startIdx;
    logic [63:0] r_line, w_line;
    logic [15:0] r_dout, w_dout;
    logic        r_burstValid, w_burstValid;
    logic        r_busAck, w_busAck;
    logic [1:0]  r_wordCnt, w_wordCnt;
    logic [2:0]  r_gapCnt, w_gapCnt;
    logic [1:0]  w_wordIdx;

    // Word 0 of a line sits in the most significant 16 bits.
    function automatic logic [15:0] selectWord(input logic [63:0] line, input logic [1:0] idx);
        case (idx)
            2'd0:    return line[63:48];
            2'd1:    return line[47:32];
            2'd2:    return line[31:16];
            default: return line[15:0];
        endcase
    endfunction

    assign w_wordIdx = r_startIdx + r_wordCnt;

    always_comb begin
        w_nextState  = r_state;
        w_memReq     = r_memReq;
        w_memAddr    = r_memAddr;
        w_startIdx   = r_startIdx;
        w_line       = r_line;
        w_dout       = r_dout;
        w_burstValid = 1'b0;
        w_busAck     = 1'b0;
        w_wordCnt    = r_wordCnt;
        w_gapCnt     = r_gapCnt;
        case (r_state)
            IDLE: begin
                if (bus.as) begin
                    w_memAddr   = bus.address[21:3];
                    w_startIdx  = bus.address[2:1];
                    w_memReq    = 1'b1;
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                // The critical word goes out straight from the memory data so it is
                // valid in the first STREAM cycle.
                if (bus.mem_valid) begin
                    w_line       = bus.mem_rdata;
                    w_memReq     = 1'b0;
                    w_dout       = selectWord(bus.mem_rdata, r_startIdx);
                    w_burstValid = 1'b1;
                    w_wordCnt    = 2'd1;
                    w_gapCnt     = GAP_LOAD;
                    w_nextState  = STREAM;
                end else if (!bus.as) begin
                    w_nextState = DRAIN;
                end
            end
            STREAM: begin
                if (r_busAck) begin
                    w_wordCnt   = 2'd0;
                    w_gapCnt    = 3'd0;
                    w_nextState = IDLE;
                end else if (r_gapCnt != 3'd0) begin
                    w_gapCnt = r_gapCnt - 3'd1;
                end else begin
                    w_dout       = selectWord(r_line, w_wordIdx);
                    w_burstValid = 1'b1;
                    w_busAck     = (r_wordCnt == 2'd3);
                    w_wordCnt    = r_wordCnt + 2'd1;
                    w_gapCnt     = GAP_LOAD;
                end
            end
            DRAIN: begin
                if (bus.mem_valid) begin
                    w_memReq    = 1'b0;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_memReq     <= 1'b0;
            r_memAddr    <= '0;
            r_startIdx   <= '0;
            r_line       <= '0;
            r_dout       <= '0;
            r_burstValid <= 1'b0;
            r_busAck     <= 1'b0;
            r_wordCnt    <= '0;
            r_gapCnt     <= '0;
        end else begin
            r_state      <= w_nextState;
            r_memReq     <= w_memReq;
            r_memAddr    <= w_memAddr;
            r_startIdx   <= w_startIdx;
            r_line       <= w_line;
            r_dout       <= w_dout;
            r_burstValid <= w_burstValid;
            r_busAck     <= w_busAck;
            r_wordCnt    <= w_wordCnt;
            r_gapCnt     <= w_gapCnt;
        end
    end

    assign bus.dout            = r_dout;
    assign bus.burstdata_valid = r_burstValid;
    assign bus.bus_ack         = r_busAck;
    assign bus.mem_req         = r_memReq;
    assign bus.mem_addr        = r_memAddr;

endmodule

// File: tb/tb_ica_dca_mem_responder.sv
// Directed bench for the burst responder: one GAP=0 and one GAP=2 instance,
// stimulus pushes expected words into per-instance queues, a monitor scores them.
module tb_ica_dca_mem_responder;

    typedef struct {
        logic [15:0] data;
        logic        ack;
        int          spacing;
    } expected_t;

    logic clk;
    logic tbReset;
    int   sel;
    logic [21:0] tbAddr;
    logic        tbAs;
    logic        tbMemValid;
    logic [63:0] tbRdata;

    int compared;
    int mismatched;
    int seenWords;
    int totalExpected;
    int cycleCnt;
    int lastCycle [2];
    expected_t q0[$];
    expected_t q1[$];

    logic        mReq, bdv, bAck;
    logic [15:0] dOut;
    logic [18:0] mAddr;

    ica_dca_mem_responder_if if0();
    ica_dca_mem_responder_if if1();

    ica_dca_mem_responder #(.GAP(0)) dut0 (.clk(clk), .reset(tbReset), .bus(if0.slave));
    ica_dca_mem_responder #(.GAP(2)) dut1 (.clk(clk), .reset(tbReset), .bus(if1.slave));

    assign if0.address   = tbAddr;
    assign if1.address   = tbAddr;
    assign if0.mem_rdata = tbRdata;
    assign if1.mem_rdata = tbRdata;
    assign if0.as        = tbAs & (sel == 0);
    assign if1.as        = tbAs & (sel == 1);
    assign if0.mem_valid = tbMemValid & (sel == 0);
    assign if1.mem_valid = tbMemValid & (sel == 1);

    assign mReq  = (sel == 1) ? if1.mem_req         : if0.mem_req;
    assign bdv   = (sel == 1) ? if1.burstdata_valid : if0.burstdata_valid;
    assign bAck  = (sel == 1) ? if1.bus_ack         : if0.bus_ack;
    assign dOut  = (sel == 1) ? if1.dout            : if0.dout;
    assign mAddr = (sel == 1) ? if1.mem_addr        : if0.mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic pushBurst(input int which, input logic [63:0] seq, input int gap);
        expected_t e;
        for (int k = 0; k < 4; k++) begin
            e.data    = seq[63 - 16*k -: 16];
            e.ack     = (k == 3);
            e.spacing = (k == 0) ? 0 : gap + 1;
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        totalExpected = totalExpected + 4;
    endtask

    task automatic scoreWord(input int which, input logic valid, input logic ack, input logic [15:0] data);
        expected_t e;
        logic      empty;
        if (!valid) begin
            if (ack) begin
                compared   = compared + 1;
                mismatched = mismatched + 1;
                $display("[TB] FAIL ack_without_word dut%0d: got bus_ack=1 required 0", which);
            end
            return;
        end
        seenWords = seenWords + 1;
        empty = (which == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL unexpected_word dut%0d: got word %h required no word", which, data);
            return;
        end
        if (which == 0) e = q0.pop_front();
        else            e = q1.pop_front();
        compared = compared + 1;
        if (data !== e.data || ack !== e.ack) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL word dut%0d: got %h ack=%b required %h ack=%b", which, data, ack, e.data, e.ack);
        end
        if (e.spacing != 0) begin
            compared = compared + 1;
            if (cycleCnt - lastCycle[which] != e.spacing) begin
                mismatched = mismatched + 1;
                $display("[TB] FAIL word_spacing dut%0d: got %0d cycles required %0d",
                         which, cycleCnt - lastCycle[which], e.spacing);
            end
        end
        lastCycle[which] = cycleCnt;
    endtask

    always @(negedge clk) begin
        scoreWord(0, if0.burstdata_valid, if0.bus_ack, if0.dout);
        scoreWord(1, if1.burstdata_valid, if1.bus_ack, if1.dout);
    end

    task automatic waitMemReq();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mReq) break;
        end
        if (!mReq) checkOutput("mem_req_timeout", 64'(mReq), 64'd1);
    endtask

    task automatic waitAck();
        for (int i = 0; i < 60; i++) begin
            if (bAck) break;
            tick();
        end
        if (!bAck) checkOutput("bus_ack_timeout", 64'(bAck), 64'd1);
    endtask

    task automatic respond(input logic [63:0] rdata, input int lat);
        repeat (lat) tick();
        tbRdata    = rdata;
        tbMemValid = 1'b1;
        tick();
        tbMemValid = 1'b0;
    endtask

    task automatic applyStimulus(input int which, input logic [21:0] addr, input logic [18:0] expLine,
                                 input logic [63:0] rdata, input logic [63:0] expSeq,
                                 input int gap, input logic stray);
        sel = which;
        tick();
        tbAddr = addr;
        tbAs   = 1'b1;
        waitMemReq();
        checkOutput("mem_addr", 64'(mAddr), 64'(expLine));
        pushBurst(which, expSeq, gap);
        respond(rdata, 3);
        tbAs = 1'b0;
        checkOutput("first_word_latency", 64'(bdv), 64'd1);
        if (stray) begin
            tbRdata    = 64'hDEAD_BEEF_DEAD_BEEF;
            tbMemValid = 1'b1;
            tick();
            tbMemValid = 1'b0;
            checkOutput("stray_valid_no_req", 64'(mReq), 64'd0);
        end
        waitAck();
        tick();
    endtask

    initial begin
        int ackDist;
        int wordCount;
        compared      = 0;
        mismatched    = 0;
        seenWords     = 0;
        totalExpected = 0;
        cycleCnt      = 0;
        lastCycle[0]  = 0;
        lastCycle[1]  = 0;
        sel        = 0;
        tbReset    = 1'b1;
        tbAddr     = '0;
        tbAs       = 1'b0;
        tbMemValid = 1'b0;
        tbRdata    = '0;

        repeat (3) tick();
        $display("[TB] reset state");
        checkOutput("rst_dout0",     64'(if0.dout), 64'd0);
        checkOutput("rst_valid0",    64'(if0.burstdata_valid), 64'd0);
        checkOutput("rst_ack0",      64'(if0.bus_ack), 64'd0);
        checkOutput("rst_req0",      64'(if0.mem_req), 64'd0);
        checkOutput("rst_addr0",     64'(if0.mem_addr), 64'd0);
        checkOutput("rst_req1",      64'(if1.mem_req), 64'd0);
        checkOutput("rst_dout1",     64'(if1.dout), 64'd0);
        tbReset = 1'b0;

        $display("[TB] aligned and misaligned bursts");
        applyStimulus(0, 22'h000400, 19'h00080, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0, 1'b0);
        applyStimulus(0, 22'h000404, 19'h00080, 64'h1111_2222_3333_4444, 64'h3333_4444_1111_2222, 0, 1'b0);

        $display("[TB] back-to-back bursts");
        sel = 0;
        tick();
        tbAddr = 22'h000400;
        tbAs   = 1'b1;
        waitMemReq();
        checkOutput("b2b_first_addr", 64'(mAddr), 64'h080);
        pushBurst(0, 64'h1111_2222_3333_4444, 0);
        respond(64'h1111_2222_3333_4444, 3);
        waitAck();
        tbAddr  = 22'h000408;
        ackDist = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (mReq) begin
                ackDist = n;
                break;
            end
        end
        checkOutput("b2b_req_distance", 64'(ackDist), 64'd2);
        checkOutput("b2b_second_addr", 64'(mAddr), 64'h081);
        pushBurst(0, 64'hAAAA_BBBB_CCCC_DDDD, 0);
        respond(64'hAAAA_BBBB_CCCC_DDDD, 3);
        tbAs = 1'b0;
        waitAck();
        tick();

        $display("[TB] GAP=2 burst with stray mem_valid during stream");
        applyStimulus(1, 22'h000402, 19'h00080, 64'h1111_2222_3333_4444, 64'h2222_3333_4444_1111, 2, 1'b1);

        $display("[TB] mem_valid while idle");
        sel = 0;
        tick();
        tbRdata    = 64'h0BAD_0BAD_0BAD_0BAD;
        tbMemValid = 1'b1;
        tick();
        tbMemValid = 1'b0;
        checkOutput("idle_valid_req", 64'(mReq), 64'd0);
        tick();

        $display("[TB] abort in fetch");
        tbAddr = 22'h000420;
        tbAs   = 1'b1;
        waitMemReq();
        checkOutput("abort_mem_addr", 64'(mAddr), 64'h084);
        tbAs = 1'b0;
        repeat (5) tick();
        checkOutput("abort_req_held", 64'(mReq), 64'd1);
        tbRdata    = 64'hFFFF_EEEE_DDDD_CCCC;
        tbMemValid = 1'b1;
        tick();
        tbMemValid = 1'b0;
        checkOutput("abort_req_dropped", 64'(mReq), 64'd0);
        repeat (3) tick();
        applyStimulus(0, 22'h000418, 19'h00083, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888, 0, 1'b0);

        $display("[TB] reset during stream");
        sel = 0;
        tick();
        tbAddr = 22'h000400;
        tbAs   = 1'b1;
        waitMemReq();
        pushBurst(0, 64'h1111_2222_3333_4444, 0);
        respond(64'h1111_2222_3333_4444, 3);
        tbAs      = 1'b0;
        wordCount = bdv ? 1 : 0;
        for (int i = 0; i < 10 && wordCount < 2; i++) begin
            tick();
            if (bdv) wordCount = wordCount + 1;
        end
        checkOutput("reset_words_before", 64'(wordCount), 64'd2);
        tbReset = 1'b1;
        tick();
        totalExpected = totalExpected - q0.size();
        q0.delete();
        checkOutput("mid_rst_dout",  64'(dOut), 64'd0);
        checkOutput("mid_rst_valid", 64'(bdv), 64'd0);
        checkOutput("mid_rst_ack",   64'(bAck), 64'd0);
        checkOutput("mid_rst_req",   64'(mReq), 64'd0);
        checkOutput("mid_rst_addr",  64'(mAddr), 64'd0);
        tbReset = 1'b0;
        repeat (4) tick();
        applyStimulus(0, 22'h000410, 19'h00082, 64'h9999_AAAA_BBBB_CCCC, 64'h9999_AAAA_BBBB_CCCC, 0, 1'b0);

        repeat (5) tick();
        checkOutput("queue0_drained", 64'(q0.size()), 64'd0);
        checkOutput("queue1_drained", 64'(q1.size()), 64'd0);
        checkOutput("word_total", 64'(seenWords), 64'(totalExpected));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule
